insn_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the RV32I datapath. It replaces gated register/memory clocks with single-cycle write enables qualified on the one clock.
- It walks each instruction through FETCH, DECODE, EXEC, MEM and WB, and owns the shared single-port memory through a req/ready handshake.
- It consumes the 10-bit one-hot instruction-class code from the opcode decoder and the branch result from the comparator.

---
 rtl/insn_seq_ctrl_if.sv | 29 ++
 rtl/insn_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_insn_seq_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/insn_seq_ctrl_if.sv
// Control bundle between the RV32I sequencer and the datapath/memory it drives.
// The sequencer uses the master view; the datapath side uses the slave view.
interface insn_seq_ctrl_if;
  logic [9:0] code;
  logic       br_taken;
  logic       mem_ready;
  logic       ir_we;
  logic       pc_we;
  logic       rd_we;
  logic       mem_req;
  logic       mem_we;
  logic       addr_sel;
  logic       pc_next_sel;
  logic       halted;
  logic       fault;
  logic [2:0] state;

  modport master (
    input  code, br_taken, mem_ready,
    output ir_we, pc_we, rd_we, mem_req, mem_we, addr_sel, pc_next_sel,
           halted, fault, state
  );

  modport slave (
    output code, br_taken, mem_ready,
    input  ir_we, pc_we, rd_we, mem_req, mem_we, addr_sel, pc_next_sel,
           halted, fault, state
  );
endinterface

// File: rtl/insn_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I datapath; emits
// single-cycle write enables and owns the shared memory req/ready handshake.
module insn_seq_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic            clk,
  input  logic            reset,
  insn_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    C_ALU, C_JUMP, C_BRANCH, C_LOAD, C_STORE
  } class_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  state_e           st;
  class_e           cls;
  class_e           code_class;
  logic [CNT_W-1:0] cnt;
  logic             live;
  logic             active;
  logic             one_hot;

  // live stays low for the cycle after reset releases, so no enable or
  // request can fire until the sequencer has seen one clean edge.
  assign active  = live & ~reset;
  assign one_hot = (bus.code != 10'd0) && ((bus.code & (bus.code - 10'd1)) == 10'd0);

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the
    // variable unassigned; otherwise synthesis infers a latch.
    code_class = C_ALU;
    if (bus.code[8])                    code_class = C_LOAD;
    else if (bus.code[6])               code_class = C_STORE;
    else if (bus.code[4])               code_class = C_BRANCH;
    else if (bus.code[0] | bus.code[1]) code_class = C_JUMP;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      st   <= S_FETCH;
      cnt  <= '0;
      live <= 1'b0;
      cls  <= C_ALU;
    end else begin
      live <= 1'b1;
      if (live) begin
        case (st)
          S_FETCH, S_MEM: begin
            // ready wins over the timeout when both land on the same cycle
            if (bus.mem_ready) begin
              cnt <= '0;
              if (st == S_FETCH)     st <= S_DECODE;
              else if (cls == C_LOAD) st <= S_WB;
              else                   st <= S_FETCH;
            end else if (cnt == CNT_MAX) begin
              cnt <= '0;
              st  <= S_FAULT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_DECODE: begin
            cls <= code_class;
            if (!one_hot)         st <= S_FAULT;
            else if (bus.code[9]) st <= S_HALT;
            else                  st <= S_EXEC;
          end
          S_EXEC: begin
            if (cls == C_LOAD || cls == C_STORE) st <= S_MEM;
            else if (cls == C_BRANCH)            st <= S_FETCH;
            else                                 st <= S_WB;
          end
          S_WB:            st <= S_FETCH;
          S_HALT, S_FAULT: st <= st;
          default:         st <= S_FAULT;
        endcase
      end
    end
  end

  always_comb begin
    bus.ir_we       = 1'b0;
    bus.pc_we       = 1'b0;
    bus.rd_we       = 1'b0;
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.addr_sel    = 1'b0;
    bus.pc_next_sel = 1'b0;
    bus.halted      = 1'b0;
    bus.fault       = 1'b0;
    if (active) begin
      case (st)
        S_FETCH: begin
          bus.mem_req = 1'b1;
          bus.ir_we   = bus.mem_ready;
        end
        S_EXEC: begin
          bus.pc_we       = (cls != C_LOAD) && (cls != C_STORE);
          bus.pc_next_sel = (cls == C_BRANCH) ? bus.br_taken : (cls == C_JUMP);
        end
        S_MEM: begin
          bus.mem_req  = 1'b1;
          bus.addr_sel = 1'b1;
          bus.mem_we   = (cls == C_STORE);
          bus.pc_we    = bus.mem_ready && (cls == C_STORE);
        end
        S_WB: begin
          bus.rd_we = 1'b1;
          bus.pc_we = (cls == C_LOAD);
        end
        S_HALT:  bus.halted = 1'b1;
        S_FAULT: bus.fault  = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.state = st;

endmodule

// File: tb/tb_insn_seq_ctrl.sv
// Self-checking bench for insn_seq_ctrl: a per-instruction trace model builds
// the expected cycle-by-cycle outputs from the instruction class and delays.
module tb_insn_seq_ctrl;
  localparam int TMO = 15;

  // signal bit positions inside the 9-bit expected/observed control vector
  localparam logic [8:0] IR   = 9'b1_0000_0000;
  localparam logic [8:0] PC   = 9'b0_1000_0000;
  localparam logic [8:0] RD   = 9'b0_0100_0000;
  localparam logic [8:0] REQ  = 9'b0_0010_0000;
  localparam logic [8:0] WE   = 9'b0_0001_0000;
  localparam logic [8:0] ASEL = 9'b0_0000_1000;
  localparam logic [8:0] NSEL = 9'b0_0000_0100;
  localparam logic [8:0] HLT  = 9'b0_0000_0010;
  localparam logic [8:0] FLT  = 9'b0_0000_0001;

  typedef struct {
    logic [11:0] exp;
    int          rdy;   // 0/1 driven value, 2 = random
    int          br;    // 0/1 driven value, 2 = random
  } entry_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  entry_t q[$];

  insn_seq_ctrl_if bus ();

  insn_seq_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [11:0] observed();
    return {bus.state, bus.ir_we, bus.pc_we, bus.rd_we, bus.mem_req, bus.mem_we,
            bus.addr_sel, bus.pc_we & bus.pc_next_sel, bus.halted, bus.fault};
  endfunction

  function automatic void push(logic [2:0] st, logic [8:0] sig, int rdy, int br = 2);
    entry_t e;
    e.exp = {st, sig};
    e.rdy = rdy;
    e.br  = br;
    q.push_back(e);
  endfunction

  function automatic void push_terminal(logic [2:0] st, logic [8:0] sig);
    repeat (3) push(st, sig, 2);
  endfunction

  // Expected trace of one instruction, from FETCH until back in FETCH or stuck.
  // fd/md are the cycles mem_ready stays low before it rises in FETCH/MEM.
  function automatic void build(logic [9:0] code, logic br, int fd, int md);
    logic       store;
    logic [8:0] mem_sig;
    q.delete();
    if (fd > TMO) begin
      repeat (TMO + 1) push(3'd0, REQ, 0);
      push_terminal(3'd6, FLT);
      return;
    end
    repeat (fd) push(3'd0, REQ, 0);
    push(3'd0, REQ | IR, 1);
    push(3'd1, 9'd0, 2);
    if ($countones(code) != 1) begin
      push_terminal(3'd6, FLT);
      return;
    end
    if (code[9]) begin
      push_terminal(3'd5, HLT);
      return;
    end
    if (code[4]) begin
      push(3'd2, PC | (br ? NSEL : 9'd0), 2, int'(br));
    end else if (code[0] | code[1]) begin
      push(3'd2, PC | NSEL, 2, int'(br));
      push(3'd4, RD, 2);
    end else if (code[6] | code[8]) begin
      store   = code[6];
      mem_sig = REQ | ASEL | (store ? WE : 9'd0);
      push(3'd2, 9'd0, 2, int'(br));
      if (md > TMO) begin
        repeat (TMO + 1) push(3'd3, mem_sig, 0);
        push_terminal(3'd6, FLT);
        return;
      end
      repeat (md) push(3'd3, mem_sig, 0);
      if (store) begin
        push(3'd3, mem_sig | PC, 1);
      end else begin
        push(3'd3, mem_sig, 1);
        push(3'd4, RD | PC, 2);
      end
    end else begin
      push(3'd2, PC, 2, int'(br));
      push(3'd4, RD, 2);
    end
  endfunction

  // Drive the trace one cycle at a time; stop < 0 runs the whole trace.
  task automatic run(string name, logic [9:0] code, int stop = -1);
    int n;
    n = (stop < 0) ? q.size() : stop;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.code      = code;
      bus.mem_ready = (q[i].rdy == 2) ? 1'($urandom) : 1'(q[i].rdy);
      bus.br_taken  = (q[i].br == 2) ? 1'($urandom) : 1'(q[i].br);
      @(negedge clk);
      checks++;
      if (observed() !== q[i].exp) begin
        errors++;
        $display("FAIL %s cycle %0d: got state=%0d ctl=%b, want state=%0d ctl=%b",
                 name, i, observed() >> 9, observed() & 12'h1ff,
                 q[i].exp >> 9, q[i].exp & 12'h1ff);
      end
    end
  endtask

  task automatic do_reset(string name);
    @(posedge clk);
    #1;
    reset         = 1'b1;
    bus.mem_ready = 1'b1;
    bus.br_taken  = 1'b1;
    @(negedge clk);
    checks++;
    if ((observed() & 12'h1ff) !== 12'h0) begin
      errors++;
      $display("FAIL %s reset cycle: got ctl=%b, want all zero", name, observed() & 12'h1ff);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (observed() !== 12'h0) begin
      errors++;
      $display("FAIL %s after reset: got state=%0d ctl=%b, want state=0 ctl=0",
               name, observed() >> 9, observed() & 12'h1ff);
    end
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.code      = 10'h020;
    bus.mem_ready = 1'b0;
    bus.br_taken  = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (observed() !== 12'h0) begin
      errors++;
      $display("FAIL reset_state: got state=%0d ctl=%b, want state=0 ctl=0",
               observed() >> 9, observed() & 12'h1ff);
    end
    do_reset("reset_release");
  endtask

  task automatic test_alu();
    build(10'h020, 1'b0, 0, 0);  run("r_alu", 10'h020);
    build(10'h080, 1'b1, 2, 0);  run("i_alu", 10'h080);
    build(10'h008, 1'b0, 1, 0);  run("lui", 10'h008);
    build(10'h004, 1'b1, 0, 0);  run("auipc", 10'h004);
    build(10'h001, 1'b0, 0, 0);  run("jal", 10'h001);
    build(10'h002, 1'b0, 3, 0);  run("jalr", 10'h002);
  endtask

  task automatic test_branch();
    build(10'h010, 1'b1, 0, 0);  run("branch_taken", 10'h010);
    build(10'h010, 1'b0, 0, 0);  run("branch_not_taken", 10'h010);
  endtask

  task automatic test_load();
    build(10'h100, 1'b0, 0, 3);  run("load_delayed", 10'h100);
    build(10'h100, 1'b0, 1, 0);  run("load_fast", 10'h100);
  endtask

  task automatic test_store();
    build(10'h040, 1'b0, 0, 0);  run("store", 10'h040);
    build(10'h040, 1'b1, 2, 2);  run("store_delayed", 10'h040);
  endtask

  task automatic test_timeout();
    build(10'h020, 1'b0, TMO + 1, 0);  run("fetch_timeout", 10'h020);
    do_reset("fetch_timeout_reset");
    build(10'h020, 1'b0, TMO, 0);      run("fetch_ready_at_limit", 10'h020);
    build(10'h100, 1'b0, 0, TMO + 1);  run("mem_timeout", 10'h100);
    do_reset("mem_timeout_reset");
    build(10'h040, 1'b0, 0, TMO);      run("mem_ready_at_limit", 10'h040);
  endtask

  task automatic test_illegal_halt();
    build(10'h003, 1'b0, 0, 0);  run("illegal_two_bits", 10'h003);
    do_reset("illegal_reset");
    build(10'h000, 1'b0, 1, 0);  run("illegal_zero", 10'h000);
    do_reset("zero_reset");
    build(10'h200, 1'b0, 0, 0);  run("halt", 10'h200);
    do_reset("halt_reset");
  endtask

  task automatic test_reset_mid();
    build(10'h100, 1'b0, 0, 10); run("reset_in_mem", 10'h100, 5);
    do_reset("reset_in_mem");
    build(10'h020, 1'b0, 0, 0);  run("reset_in_wb", 10'h020, 3);
    do_reset("reset_in_wb");
    build(10'h020, 1'b0, 0, 0);  run("after_mid_reset", 10'h020);
  endtask

  task automatic test_random();
    logic [9:0] codes [12];
    logic [9:0] code;
    int         fd, md;
    codes = '{10'h001, 10'h002, 10'h004, 10'h008, 10'h010, 10'h020,
              10'h040, 10'h080, 10'h100, 10'h200, 10'h000, 10'h180};
    for (int i = 0; i < 40; i++) begin
      code = (($urandom % 8) == 0) ? codes[$urandom_range(9, 11)] : codes[$urandom_range(0, 8)];
      fd   = (($urandom % 10) == 0) ? $urandom_range(TMO, TMO + 1) : $urandom_range(0, 3);
      md   = (($urandom % 10) == 0) ? $urandom_range(TMO, TMO + 1) : $urandom_range(0, 4);
      build(code, 1'($urandom), fd, md);
      run("random", code);
      if (q[q.size()-1].exp[1:0] != 2'b00) do_reset("random_reset");
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_load();
    test_store();
    test_timeout();
    test_illegal_halt();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
